// File: rtl/fir_interpolator.sv
// Polyphase 1:4 interpolating FIR: one input sample yields four filtered
// outputs (phases 0..3), evaluated by a single sequential 8-tap MAC.
//
// Ports:
//   clk_in     : system clock, all logic on posedge
//   rst_in     : synchronous active-high reset
//   audio_in   : signed input sample, taken on an accepted valid_in
//   valid_in   : one-cycle strobe marking a new input sample
//   ready_out  : high when a valid_in will be accepted
//   audio_out  : signed interpolated sample, held between updates
//   data_ready : one-cycle pulse, audio_out updated this cycle
//   overrun    : sticky, set by a valid_in arriving while busy
module fir_interpolator #(
    parameter int WIDTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] audio_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] audio_out,
    output logic                    data_ready,
    output logic                    overrun
);

    localparam int ACC_W = WIDTH + 13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic [1:0]              state;
    logic [1:0]              phase;
    logic [2:0]              tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] dline [8];

    logic signed [9:0]       coef;
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] shifted;
    logic signed [WIDTH-1:0] sat;

    // Tap index p+4k packs as {k, p}.
    function automatic logic signed [9:0] coef_rom(input logic [4:0] idx);
        case (idx)
            5'd5:    return 10'sd3;
            5'd6:    return 10'sd4;
            5'd8:    return -10'sd8;
            5'd9:    return -10'sd25;
            5'd10:   return -10'sd20;
            5'd12:   return 10'sd60;
            5'd13:   return 10'sd150;
            5'd14:   return 10'sd220;
            5'd15:   return 10'sd256;
            5'd16:   return 10'sd220;
            5'd17:   return 10'sd150;
            5'd18:   return 10'sd60;
            5'd20:   return -10'sd20;
            5'd21:   return -10'sd25;
            5'd22:   return -10'sd8;
            5'd24:   return 10'sd4;
            5'd25:   return 10'sd3;
            default: return 10'sd0;
        endcase
    endfunction

    always_comb begin
        coef     = coef_rom({tap, phase});
        coef_ext = ACC_W'(coef);
        samp_ext = ACC_W'(dline[tap]);
        prod     = coef_ext * samp_ext;
        // Arithmetic shift floors toward minus infinity.
        shifted  = acc >>> 8;
        sat      = shifted[WIDTH-1:0];
        if (shifted > SAT_HI) begin
            sat = SAT_HI[WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            sat = SAT_LO[WIDTH-1:0];
        end
    end

    assign ready_out = (state == S_IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            phase      <= 2'd0;
            tap        <= 3'd0;
            acc        <= '0;
            audio_out  <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                dline[i] <= '0;
            end
        end else begin
            data_ready <= 1'b0;
            if (valid_in && !ready_out) begin
                overrun <= 1'b1;
            end
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (valid_in) begin
                        dline[0] <= audio_in;
                        for (int i = 1; i < 8; i++) begin
                            dline[i] <= dline[i-1];
                        end
                        phase <= 2'd0;
                        tap   <= 3'd0;
                        acc   <= '0;
                        state <= S_MAC;
                    end
                end
                (state == S_MAC): begin
                    acc <= acc + prod;
                    tap <= tap + 3'd1;
                    if (tap == 3'd7) begin
                        state <= S_EMIT;
                    end
                end
                (state == S_EMIT): begin
                    audio_out  <= sat;
                    data_ready <= 1'b1;
                    acc        <= '0;
                    tap        <= 3'd0;
                    if (phase == 2'd3) begin
                        state <= S_IDLE;
                    end else begin
                        phase <= phase + 2'd1;
                        state <= S_MAC;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interpolator.sv
// Scoreboard bench for fir_interpolator: stimulus pushes expected
// outputs from an arithmetic reference, a monitor pops and compares.
module tb_fir_interpolator;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic signed [7:0] audio_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic signed [7:0] audio_out;
    logic              data_ready;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    int H [32] = '{0, 0, 0, 0, 0, 3, 4, 0, -8, -25, -20, 0, 60, 150, 220,
                   256, 220, 150, 60, 0, -20, -25, -8, 0, 4, 3, 0, 0, 0, 0,
                   0, 0};

    int hist [8];
    int expq [$];
    int seen [$];
    int dr_count = 0;
    bit prev_dr = 1'b0;

    fir_interpolator #(.WIDTH(8)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .audio_in  (audio_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .audio_out (audio_out),
        .data_ready(data_ready),
        .overrun   (overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic int floor_div256(input int v);
        if (v >= 0) return v / 256;
        return -((-v + 255) / 256);
    endfunction

    // Reference: history of the last eight accepted samples, then the
    // direct polyphase sum for each requested phase.
    function automatic void model_accept(input int s, input int nph);
        int y;
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        for (int p = 0; p < nph; p++) begin
            y = 0;
            for (int k = 0; k < 8; k++) y += H[p + 4*k] * hist[k];
            y = floor_div256(y);
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            expq.push_back(y);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) hist[k] = 0;
    endfunction

    always @(negedge clk_in) begin
        if (!rst_in && data_ready) begin
            int want;
            dr_count++;
            seen.push_back(int'(audio_out));
            if (prev_dr) check("data_ready_consecutive", 1, 0);
            if (expq.size() == 0) begin
                check("unexpected_output", int'(audio_out), 9999);
            end else begin
                want = expq.pop_front();
                check("audio_out", int'(audio_out), want);
            end
        end
        prev_dr = data_ready;
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        model_clear();
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_in);
        while (!ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!ready_out) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int s);
        wait_ready();
        audio_in = 8'(s);
        valid_in = 1'b1;
        model_accept(s, 4);
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        check("drain_empty", expq.size(), 0);
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        int base;
        int s;
        int cnt0;
        model_clear();

        // Reset values.
        do_reset();
        check("rst_ready_out", int'(ready_out), 1);
        check("rst_data_ready", int'(data_ready), 0);
        check("rst_audio_out", int'(audio_out), 0);
        check("rst_overrun", int'(overrun), 0);

        // Reset at cycle 12 aborts; only phase 0 output appears.
        wait_ready();
        audio_in = 8'sd90;
        valid_in = 1'b1;
        model_accept(90, 1);
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        repeat (11) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("abort_ready_out", int'(ready_out), 1);
        check("abort_data_ready", int'(data_ready), 0);
        check("abort_audio_out", int'(audio_out), 0);
        rst_in = 1'b0;
        model_clear();
        cnt0 = dr_count;
        repeat (45) @(negedge clk_in);
        check("abort_no_pulses", dr_count - cnt0, 0);
        check("abort_queue_empty", expq.size(), 0);

        // Impulse response.
        do_reset();
        base = seen.size();
        send(64);
        for (int i = 0; i < 7; i++) send(0);
        drain();
        for (int i = 0; i < 6; i++)
            check("impulse_zero", seen[base + i], 0);
        check("impulse_12", seen[base + 12], 15);
        check("impulse_13", seen[base + 13], 37);
        check("impulse_14", seen[base + 14], 55);
        check("impulse_15", seen[base + 15], 64);

        // DC +100 then -128.
        do_reset();
        for (int i = 0; i < 10; i++) send(100);
        drain();
        for (int i = 1; i <= 8; i++)
            check("dc_pos", seen[seen.size() - i], 100);
        for (int i = 0; i < 10; i++) send(-128);
        drain();
        for (int i = 1; i <= 8; i++)
            check("dc_neg", seen[seen.size() - i], -128);

        // Saturation.
        do_reset();
        send(127); send(-128); send(127); send(127);
        send(-128); send(127); send(0);
        drain();
        check("sat_phase1", seen[seen.size() - 3], 127);

        // Timing and overrun.
        do_reset();
        wait_ready();
        audio_in = 8'sd50;
        valid_in = 1'b1;
        model_accept(50, 4);
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("timing_dr_c%0d", c), int'(data_ready),
                  (c == 9 || c == 18 || c == 27 || c == 36) ? 1 : 0);
            check($sformatf("timing_rdy_c%0d", c), int'(ready_out),
                  (c == 36) ? 1 : 0);
            if (c == 19) begin
                check("overrun_before", int'(overrun), 0);
                audio_in = -8'sd77;
                valid_in = 1'b1;
            end
            if (c == 20) begin
                valid_in = 1'b0;
                check("overrun_set", int'(overrun), 1);
            end
            if (c == 36) begin
                audio_in = 8'sd33;
                valid_in = 1'b1;
                model_accept(33, 4);
            end
        end
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        check("accept_c36_busy", int'(ready_out), 0);
        check("overrun_kept", int'(overrun), 1);
        drain();

        // Back-to-back random.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            s = int'($urandom_range(255)) - 128;
            send(s);
        end
        drain();
        check("random_overrun", int'(overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
